// File: rtl/deinterleave_ctrl_if.sv
// -----------------------------------------------------------------------------
// deinterleave_ctrl_if
// Bundle of the byte-stream, delay-line RAM and output signals around the
// I=12 / M=17 convolutional deinterleaver controller.
//
//  Stream in : in_valid, in_data[7:0], in_sync
//  RAM side  : push[10:0], sel[3:0], ram_re, ram_din[7:0], ram_dout[7:0]
//  Stream out: out_valid, out_data[7:0], out_sync, sync_err, locked
//
//  modport master : the controller view (drives RAM strobes and the output stream)
//  modport slave  : the environment view (source of bytes, the RAM, the consumer)
// -----------------------------------------------------------------------------
interface deinterleave_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sync;
  logic [10:0] push;
  logic [3:0]  sel;
  logic        ram_re;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sync;
  logic        sync_err;
  logic        locked;

  modport master (
    input  in_valid, in_data, in_sync, ram_dout,
    output push, sel, ram_re, ram_din,
    output out_valid, out_data, out_sync, sync_err, locked
  );

  modport slave (
    output in_valid, in_data, in_sync, ram_dout,
    input  push, sel, ram_re, ram_din,
    input  out_valid, out_data, out_sync, sync_err, locked
  );
endinterface

// File: rtl/deinterleave_ctrl.sv
// -----------------------------------------------------------------------------
// deinterleave_ctrl
// Receive-side commutator for the I=12, M=17 byte convolutional deinterleaver.
// Branch j (0..11) is delayed (11-j)*17 laps through one level of an external
// fifo_shift_ram; branch 11 bypasses the RAM through a one-clock holding
// register. Byte alignment is acquired from the sync flag and the output is
// qualified until every delay line has been filled once after lock.
//
// Ports
//  clk    : rising-edge clock
//  reset  : asynchronous, active-high reset
//  bus    : deinterleave_ctrl_if.master
//           in_valid/in_data/in_sync : incoming interleaved bytes, no backpressure
//           push/sel/ram_re/ram_din  : RAM level strobe, level select, read enable, write data
//           ram_dout                 : RAM read data, valid one clock after ram_re
//           out_valid/out_data       : deinterleaved byte, one clock after its input
//           out_sync                 : output byte was branch 0 of a lap
//           sync_err                 : one-clock pulse on a misaligned sync in LOCK
//           locked                   : FSM is in LOCK
// -----------------------------------------------------------------------------
module deinterleave_ctrl #(
  parameter int FILL_BYTES = 2244,
  parameter int SYNC_LOSS  = 3
) (
  input  logic                clk,
  input  logic                reset,
  deinterleave_ctrl_if.master bus
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic [11:0] FILL_C      = 12'(FILL_BYTES);
  localparam logic [1:0]  LOSS_LAST_C = 2'(SYNC_LOSS - 1);
  localparam logic [3:0]  BR_LAST_C   = 4'd11;

  state_e      state_q;
  logic [3:0]  br_q;
  logic [11:0] fill_cnt_q;
  logic [1:0]  miss_cnt_q;
  logic        primed_q;
  logic        out_valid_q;
  logic        out_sync_q;
  logic        sync_err_q;
  logic        byp_sel_q;
  logic [7:0]  byp_q;

  logic        lock_s;
  logic        hunt_hit_s;
  logic        sync_mis_s;
  logic        loss_s;
  logic        accept_s;
  logic        ram_wr_s;
  logic [11:0] fill_d;
  logic        primed_d;
  logic [3:0]  lvl_s;
  logic [10:0] push_s;
  logic [7:0]  din_s;
  logic [7:0]  out_data_s;

  // Per-byte decode: lock acquisition, sync checking and byte acceptance.
  always_comb begin
    lock_s     = (state_q == LOCK);
    hunt_hit_s = !lock_s && bus.in_valid && bus.in_sync;
    sync_mis_s = lock_s && bus.in_valid && bus.in_sync && (br_q != 4'd0);
    // The misaligned sync that exhausts the budget drops lock before the byte is used.
    loss_s     = sync_mis_s && (miss_cnt_q == LOSS_LAST_C);
    // The sync byte that achieves lock is itself processed as branch 0.
    accept_s   = hunt_hit_s || (lock_s && bus.in_valid && !loss_s);
    ram_wr_s   = accept_s && (br_q != BR_LAST_C);
    if (accept_s && (fill_cnt_q != FILL_C)) begin
      fill_d = fill_cnt_q + 12'd1;
    end else begin
      fill_d = fill_cnt_q;
    end
    // The byte that completes the fill count already produces a valid output.
    primed_d = primed_q || (fill_d == FILL_C);
  end

  // RAM strobes: branch br uses level 11-br, i.e. push bit / sel value 10-br.
  always_comb begin
    if (ram_wr_s) begin
      lvl_s  = 4'd10 - br_q;
      push_s = 11'd1 << lvl_s;
      din_s  = bus.in_data;
    end else begin
      lvl_s  = 4'd0;
      push_s = 11'd0;
      din_s  = 8'd0;
    end
  end

  // Output byte source: bypass register for branch 11, otherwise the RAM read.
  always_comb begin
    if (!out_valid_q) begin
      out_data_s = 8'd0;
    end else if (byp_sel_q) begin
      out_data_s = byp_q;
    end else begin
      out_data_s = bus.ram_dout;
    end
  end

  assign bus.push      = push_s;
  assign bus.sel       = lvl_s;
  assign bus.ram_re    = ram_wr_s;
  assign bus.ram_din   = din_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_s;
  assign bus.out_sync  = out_sync_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.locked    = (state_q == LOCK);

  // HUNT/LOCK state machine with commutator, fill and miss counters and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      br_q        <= 4'd0;
      fill_cnt_q  <= 12'd0;
      miss_cnt_q  <= 2'd0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_q       <= 8'd0;
    end else begin
      sync_err_q  <= sync_mis_s;
      out_valid_q <= accept_s && primed_d;
      out_sync_q  <= accept_s && (br_q == 4'd0);
      byp_sel_q   <= accept_s && (br_q == BR_LAST_C);
      if (accept_s && (br_q == BR_LAST_C)) begin
        byp_q <= bus.in_data;
      end else begin
        byp_q <= byp_q;
      end

      case (state_q)
        HUNT: begin
          if (hunt_hit_s) begin
            state_q    <= LOCK;
            br_q       <= 4'd1;
            fill_cnt_q <= fill_d;
            primed_q   <= primed_d;
            miss_cnt_q <= 2'd0;
          end else begin
            state_q    <= HUNT;
            br_q       <= 4'd0;
            fill_cnt_q <= 12'd0;
            primed_q   <= 1'b0;
            miss_cnt_q <= 2'd0;
          end
        end
        LOCK: begin
          if (loss_s) begin
            state_q    <= HUNT;
            br_q       <= 4'd0;
            fill_cnt_q <= 12'd0;
            primed_q   <= 1'b0;
            miss_cnt_q <= 2'd0;
          end else if (bus.in_valid) begin
            br_q       <= (br_q == BR_LAST_C) ? 4'd0 : (br_q + 4'd1);
            fill_cnt_q <= fill_d;
            primed_q   <= primed_d;
            // Misaligned syncs are only counted; the commutator is never realigned.
            if (bus.in_sync) begin
              miss_cnt_q <= (br_q == 4'd0) ? 2'd0 : (miss_cnt_q + 2'd1);
            end else begin
              miss_cnt_q <= miss_cnt_q;
            end
          end else begin
            br_q       <= br_q;
            fill_cnt_q <= fill_cnt_q;
            primed_q   <= primed_q;
            miss_cnt_q <= miss_cnt_q;
          end
        end
        default: begin
          state_q    <= HUNT;
          br_q       <= 4'd0;
          fill_cnt_q <= 12'd0;
          primed_q   <= 1'b0;
          miss_cnt_q <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deinterleave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_deinterleave_ctrl
// Directed bench for deinterleave_ctrl with a behavioural fifo_shift_ram and a
// closed-form reference interleaver: channel byte p carries ramp value
// p - 204*(p mod 12), so the deinterleaved byte at position p must be p - 2244.
// -----------------------------------------------------------------------------
module tb_deinterleave_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  deinterleave_ctrl_if bus ();

  deinterleave_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural delay-line RAM: level L (sel) holds 17*(L+1) bytes.
  logic [7:0] mem [11][187];
  int         ptr [11];
  int         ram_lvl;
  assign ram_lvl = int'(bus.sel);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) ptr[i] <= 0;
      bus.ram_dout <= 8'd0;
    end else if (bus.ram_re && (ram_lvl <= 10)) begin
      bus.ram_dout <= mem[ram_lvl][ptr[ram_lvl]];
      if (bus.push != 11'd0) mem[ram_lvl][ptr[ram_lvl]] <= bus.ram_din;
      ptr[ram_lvl] <= (ptr[ram_lvl] == 17 * (ram_lvl + 1) - 1) ? 0 : ptr[ram_lvl] + 1;
    end
  end

  int         checks;
  int         errors;
  bit         tb_lock;
  int         k;
  int         miss;
  logic [8:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int p);
    int v;
    v = p - 204 * (p % 12);
    return v[7:0];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_push"},      32'(bus.push),      32'd0);
    chk({tag, "_sel"},       32'(bus.sel),       32'd0);
    chk({tag, "_ram_re"},    32'(bus.ram_re),    32'd0);
    chk({tag, "_ram_din"},   32'(bus.ram_din),   32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_out_sync"},  32'(bus.out_sync),  32'd0);
    chk({tag, "_sync_err"},  32'(bus.sync_err),  32'd0);
    chk({tag, "_locked"},    32'(bus.locked),    32'd0);
  endtask

  // One clock: drive a byte, check RAM strobes, then check the registered result.
  task automatic send(input bit v, input logic [7:0] d, input bit s);
    int          br_e;
    int          e;
    bit          serr, loss, acc, valid;
    logic [10:0] e_push;
    logic [3:0]  e_sel;
    logic [7:0]  e_din;
    logic [8:0]  got;
    br_e  = tb_lock ? (k % 12) : 0;
    serr  = tb_lock && v && s && (br_e != 0);
    loss  = serr && (miss == 2);
    acc   = v && !loss && (tb_lock || s);
    valid = acc && (k >= 2243);
    if (acc && (br_e < 11)) begin
      e_push = 11'd1 << (10 - br_e);
      e_sel  = 4'(10 - br_e);
      e_din  = d;
    end else begin
      e_push = 11'd0;
      e_sel  = 4'd0;
      e_din  = 8'd0;
    end
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sync  = s;
    #1;
    chk("push",    32'(bus.push),    32'(e_push));
    chk("sel",     32'(bus.sel),     32'(e_sel));
    chk("ram_re",  32'(bus.ram_re),  32'(e_push != 11'd0));
    chk("ram_din", 32'(bus.ram_din), 32'(e_din));
    if (valid) begin
      e = k - 2244;
      exp_q.push_back({br_e == 0, e[7:0]});
    end
    if (loss) begin
      tb_lock = 1'b0;
      k       = 0;
      miss    = 0;
    end else if (acc) begin
      if (!tb_lock) begin
        tb_lock = 1'b1;
        miss    = 0;
      end else if (s) begin
        miss = (br_e == 0) ? 0 : miss + 1;
      end
      k++;
    end
    @(posedge clk);
    #1;
    chk("locked",    32'(bus.locked),    32'(tb_lock));
    chk("sync_err",  32'(bus.sync_err),  32'(serr));
    chk("out_valid", 32'(bus.out_valid), 32'(valid));
    if (valid) begin
      got = exp_q.pop_front();
      chk("out_data", 32'(bus.out_data), 32'(got[7:0]));
      chk("out_sync", 32'(bus.out_sync), 32'(got[8]));
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) send(1'b1, chan(k), 1'b0);
  endtask

  // Advance (at most one lap) until the next byte falls on branch b.
  task automatic to_br(input int b);
    for (int i = 0; (i < 12) && ((k % 12) != b); i++) send(1'b1, chan(k), 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero(tag);
    tb_lock = 1'b0;
    k       = 0;
    miss    = 0;
    exp_q.delete();
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    tb_lock = 1'b0;
    k       = 0;
    miss    = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    bus.in_sync  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b0;

    // Lock on the first sync byte; push walks 0x400 down to 0x001, then bypass.
    send(1'b1, 8'h47, 1'b1);
    for (int i = 1; i < 12; i++) send(1'b1, 8'(i), 1'b0);
    do_reset("rst2");

    // Ramp through the reference interleaver with a 5-clock gap mid-stream.
    send(1'b1, chan(0), 1'b1);
    stream(2599);
    send(1'b0, 8'hA5, 1'b0);
    send(1'b0, 8'hA5, 1'b1);
    send(1'b0, 8'hA5, 1'b0);
    send(1'b0, 8'hA5, 1'b0);
    send(1'b0, 8'hA5, 1'b0);
    stream(400);

    // Three misaligned syncs at branch 5 on separate laps: lock is lost on the third.
    for (int n = 0; n < 3; n++) begin
      to_br(5);
      send(1'b1, chan(k), 1'b1);
    end
    stream(20);

    // Relock and refill before the output becomes valid again.
    send(1'b1, chan(0), 1'b1);
    stream(2300);

    // One misaligned sync, then an aligned one clears the count; two more keep LOCK.
    to_br(3);
    send(1'b1, chan(k), 1'b1);
    to_br(0);
    send(1'b1, chan(k), 1'b1);
    to_br(7);
    send(1'b1, chan(k), 1'b1);
    to_br(7);
    send(1'b1, chan(k), 1'b1);
    stream(30);

    // Reset while streaming at branch 7, then relock on the next sync.
    to_br(7);
    bus.in_valid = 1'b1;
    bus.in_data  = chan(k);
    bus.in_sync  = 1'b0;
    do_reset("rst3");
    stream(5);
    send(1'b1, chan(0), 1'b1);
    stream(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
